// File: rtl/mm2s_cmd_seq.sv
// MM2S command sequencer: slices a capture region into fixed-size DataMover
// commands on an AXI-Stream master, throttled by outstanding-status credit.
module mm2s_cmd_seq #(
  parameter int PACKET_SIZE     = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        axilite_clk,
  input  logic        axilite_rstb,
  output logic [71:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic        sts_done,
  input  logic        read_start,
  input  logic        read_reset,
  input  logic        loop_en,
  input  logic [31:0] base_addr,
  input  logic [31:0] cap_size,
  output logic        busy,
  output logic [31:0] cmd_count,
  output logic [7:0]  loop_count,
  output logic [3:0]  outstanding
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ISSUE       = 2'd1,
    S_WAIT_CREDIT = 2'd2,
    S_ABORT       = 2'd3
  } state_e;

  localparam logic [31:0] PKT_BYTES = 32'(PACKET_SIZE);
  localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);

  function automatic logic [22:0] calc_btt(input logic [31:0] size, input logic [31:0] off);
    logic [31:0] rem;
    rem = size - off;
    if (rem < PKT_BYTES) begin
      calc_btt = rem[22:0];
    end else begin
      calc_btt = PKT_BYTES[22:0];
    end
  endfunction

  function automatic logic [71:0] build_cmd(input logic [31:0] saddr, input logic [22:0] btt,
                                            input logic [3:0] tag);
    build_cmd = {4'h0, tag, saddr, 1'b0, 1'b1, 6'h00, 1'b1, btt};
  endfunction

  state_e      state_q, state_d;
  logic        start_q;
  logic        arm_q;
  logic [31:0] base_q, base_d;
  logic [31:0] size_q, size_d;
  logic        loop_q, loop_d;
  logic [31:0] offset_q, offset_d;
  logic [31:0] cmd_count_q, cmd_count_d;
  logic [7:0]  loop_count_q, loop_count_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic [71:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        busy_q;

  logic        start_edge_s;
  logic        hs_s;
  logic        issue_hs_s;
  logic [31:0] cap_masked_s;
  logic [22:0] btt_cur_s;
  logic [31:0] new_off_s;
  logic        wrap_s;
  logic [31:0] next_off_s;
  logic [31:0] cmd_inc_s;

  // arm_q blocks a start level that was already high when reset released
  assign start_edge_s = read_start & ~start_q & arm_q;
  assign hs_s         = tvalid_q & m_axis_tready;
  assign issue_hs_s   = hs_s & (state_q == S_ISSUE) & ~read_reset;
  assign cap_masked_s = cap_size & 32'hFFFF_FFE0;
  assign btt_cur_s    = calc_btt(size_q, offset_q);
  assign new_off_s    = offset_q + 32'(btt_cur_s);
  assign wrap_s       = (new_off_s >= size_q);
  assign next_off_s   = wrap_s ? 32'd0 : new_off_s;
  assign cmd_inc_s    = cmd_count_q + 32'd1;

  // Credit counter: issue adds one, status return removes one, never below zero.
  always_comb begin
    outstanding_d = outstanding_q;
    if (read_reset) begin
      outstanding_d = 4'd0;
    end else if (issue_hs_s && sts_done) begin
      outstanding_d = outstanding_q;
    end else if (issue_hs_s) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (sts_done && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end else begin
      outstanding_d = outstanding_q;
    end
  end

  // Sequencer next state, command word and pass/command counters.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    size_d       = size_q;
    loop_d       = loop_q;
    offset_d     = offset_q;
    cmd_count_d  = cmd_count_q;
    loop_count_d = loop_count_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    case (state_q)
      S_IDLE: begin
        tvalid_d = 1'b0;
        if (!read_reset && start_edge_s && (cap_masked_s != 32'd0)) begin
          base_d   = base_addr;
          size_d   = cap_masked_s;
          loop_d   = loop_en;
          offset_d = 32'd0;
          tdata_d  = build_cmd(base_addr, calc_btt(cap_masked_s, 32'd0), cmd_count_q[3:0]);
          tvalid_d = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (hs_s && read_reset) begin
          tvalid_d = 1'b0;
          state_d  = S_IDLE;
        end else if (hs_s) begin
          cmd_count_d = cmd_inc_s;
          offset_d    = next_off_s;
          tdata_d     = build_cmd(base_q + next_off_s, calc_btt(size_q, next_off_s), cmd_inc_s[3:0]);
          if (wrap_s) begin
            loop_count_d = loop_count_q + 8'd1;
          end else begin
            loop_count_d = loop_count_q;
          end
          if (wrap_s && !loop_q) begin
            tvalid_d = 1'b0;
            state_d  = S_IDLE;
          end else if (outstanding_d < MAX_OUT) begin
            tvalid_d = 1'b1;
            state_d  = S_ISSUE;
          end else begin
            tvalid_d = 1'b0;
            state_d  = S_WAIT_CREDIT;
          end
        end else if (read_reset) begin
          state_d = S_ABORT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_CREDIT: begin
        // tdata already holds the next command, prepared at the last handshake
        if (read_reset) begin
          tvalid_d = 1'b0;
          state_d  = S_IDLE;
        end else if (outstanding_q < MAX_OUT) begin
          tvalid_d = 1'b1;
          state_d  = S_ISSUE;
        end else begin
          tvalid_d = 1'b0;
          state_d  = S_WAIT_CREDIT;
        end
      end
      S_ABORT: begin
        if (hs_s) begin
          tvalid_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          tvalid_d = 1'b1;
          state_d  = S_ABORT;
        end
      end
      default: begin
        tvalid_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
    if (read_reset) begin
      cmd_count_d  = 32'd0;
      loop_count_d = 8'd0;
      offset_d     = 32'd0;
    end else begin
      cmd_count_d  = cmd_count_d;
    end
  end

  // State, latched region and output registers.
  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      arm_q         <= 1'b0;
      base_q        <= 32'd0;
      size_q        <= 32'd0;
      loop_q        <= 1'b0;
      offset_q      <= 32'd0;
      cmd_count_q   <= 32'd0;
      loop_count_q  <= 8'd0;
      outstanding_q <= 4'd0;
      tdata_q       <= 72'd0;
      tvalid_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= read_start;
      arm_q         <= arm_q | ~read_start;
      base_q        <= base_d;
      size_q        <= size_d;
      loop_q        <= loop_d;
      offset_q      <= offset_d;
      cmd_count_q   <= cmd_count_d;
      loop_count_q  <= loop_count_d;
      outstanding_q <= outstanding_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign cmd_count     = cmd_count_q;
  assign loop_count    = loop_count_q;
  assign outstanding   = outstanding_q;

endmodule
